// File: rtl/alu_cmd_seq.sv
`timescale 1ns/1ps
// Command sequencer feeding a combinational alu: command FIFO -> registered
// operand stage -> response register. Optional accumulator: ALU_CMD_SEQ_ACC_EN.
module alu_cmd_seq #(
  parameter int DATA_LEN = 4,
  parameter int DEPTH    = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [DATA_LEN-1:0] cmd_a,
  input  logic [DATA_LEN-1:0] cmd_b,
  input  logic [2:0]          cmd_func,
  input  logic                cmd_acc,
  output logic [DATA_LEN-1:0] alu_a,
  output logic [DATA_LEN-1:0] alu_b,
  output logic [2:0]          alu_func,
  input  logic [DATA_LEN-1:0] alu_result,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_LEN-1:0] rsp_result,
  output logic [2:0]          rsp_func
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [DATA_LEN-1:0] a;
    logic [DATA_LEN-1:0] b;
    logic [2:0]          func;
`ifdef ALU_CMD_SEQ_ACC_EN
    logic                acc;
`endif
  } cmd_t;

  typedef enum logic [1:0] {IDLE, BUSY, STALL} op_state_e;

  cmd_t          mem [DEPTH];
  cmd_t          head;
  cmd_t          wr_ent;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          op_valid;
  op_state_e     op_state;
  logic          push, empty, op_load, rsp_load;
  logic [DATA_LEN-1:0] next_a;

  assign cmd_ready = (count != CW'(DEPTH));
  assign empty     = (count == '0);
  assign push      = cmd_valid && cmd_ready;
  assign head      = mem[rd_ptr];

  // State is a view of the registered flags, not a separate register.
  always_comb begin
    op_state = BUSY;
    if (!op_valid)                    op_state = IDLE;
    else if (rsp_valid && !rsp_ready) op_state = STALL;
  end

  assign rsp_load = op_valid && (!rsp_valid || rsp_ready);
  assign op_load  = !empty && (op_state != STALL);

  always_comb begin
    wr_ent      = '0;
    wr_ent.a    = cmd_a;
    wr_ent.b    = cmd_b;
    wr_ent.func = cmd_func;
`ifdef ALU_CMD_SEQ_ACC_EN
    wr_ent.acc  = cmd_acc;
`endif
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_ent;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)    wr_ptr <= wr_ptr + AW'(1);
      if (op_load) rd_ptr <= rd_ptr + AW'(1);
      case ({push, op_load})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef ALU_CMD_SEQ_ACC_EN
  logic [DATA_LEN-1:0] acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        acc <= '0;
    else if (rsp_load) acc <= alu_result;
  end

  // A result captured on this same edge has not reached acc yet; forward it.
  always_comb begin
    next_a = head.a;
    if (head.acc) next_a = rsp_load ? alu_result : acc;
  end
`else
  logic unused_cmd_acc;
  assign unused_cmd_acc = cmd_acc;
  assign next_a = head.a;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_valid <= 1'b0;
      alu_a    <= '0;
      alu_b    <= '0;
      alu_func <= '0;
    end else begin
      case (op_state)
        IDLE, BUSY: begin
          if (op_load) begin
            op_valid <= 1'b1;
            alu_a    <= next_a;
            alu_b    <= head.b;
            alu_func <= head.func;
          end else if (rsp_load) begin
            op_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_func   <= '0;
    end else if (rsp_load) begin
      rsp_valid  <= 1'b1;
      rsp_result <= alu_result;
      rsp_func   <= alu_func;
    end else if (rsp_ready) begin
      rsp_valid  <= 1'b0;
    end
  end
endmodule

// File: tb/tb_alu_cmd_seq.sv
`timescale 1ns/1ps
// Scoreboard bench for alu_cmd_seq with a behavioural alu attached.
module tb_alu_cmd_seq;
  localparam int DL    = 4;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0, cmd_ready, cmd_acc = 1'b0;
  logic [DL-1:0] cmd_a = '0, cmd_b = '0;
  logic [2:0]    cmd_func = '0;
  logic [DL-1:0] alu_a, alu_b, alu_result, rsp_result;
  logic [2:0]    alu_func, rsp_func;
  logic          rsp_valid, rsp_ready = 1'b0;

  typedef struct packed {
    logic [DL-1:0] res;
    logic [2:0]    func;
  } exp_t;

  exp_t sb[$];
  int errors = 0;
  int checks = 0;

  alu_cmd_seq #(.DATA_LEN(DL), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_func(cmd_func), .cmd_acc(cmd_acc),
    .alu_a(alu_a), .alu_b(alu_b), .alu_func(alu_func), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_func(rsp_func)
  );

  always #5 clk = ~clk;

  // Stand-in alu: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 not, 110 less, 111 equal.
  function automatic logic [DL-1:0] ref_alu(input logic [DL-1:0] a, input logic [DL-1:0] b,
                                            input logic [2:0] f);
    case (f)
      3'b000:  return a + b;
      3'b001:  return a - b;
      3'b010:  return a & b;
      3'b011:  return a | b;
      3'b100:  return a ^ b;
      3'b101:  return ~a;
      3'b110:  return {{(DL-1){1'b0}}, (a < b)};
      default: return {{(DL-1){1'b0}}, (a == b)};
    endcase
  endfunction

  always_comb alu_result = ref_alu(alu_a, alu_b, alu_func);

  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_rsp: got result=%b func=%b, scoreboard empty", rsp_result, rsp_func);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (rsp_result !== e.res || rsp_func !== e.func) begin
          errors++;
          $display("FAIL rsp_data: got result=%b func=%b, want result=%b func=%b",
                   rsp_result, rsp_func, e.res, e.func);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic push(input logic [DL-1:0] a, input logic [DL-1:0] b, input logic [2:0] f,
                      input logic acc, input logic [DL-1:0] res, input bit want, output logic rdy);
    cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_func = f; cmd_acc = acc;
    @(negedge clk);
    rdy = cmd_ready;
    if (want) sb.push_back('{res: res, func: f});
    @(posedge clk); #1;
  endtask

  // Waits (bounded) for a response, then counts consecutive valid cycles.
  task automatic count_run(output int n);
    int w;
    n = 0; w = 0;
    @(negedge clk);
    while (!rsp_valid && w < 20) begin @(negedge clk); w++; end
    while (rsp_valid && n < 50) begin n++; @(negedge clk); end
  endtask

  task automatic test_reset;
    #1;
    checks++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_hs: cmd_ready=%b rsp_valid=%b, want 1/0", cmd_ready, rsp_valid);
    end
    checks++;
    if (alu_a !== '0 || alu_b !== '0 || alu_func !== '0 || rsp_result !== '0 || rsp_func !== '0) begin
      errors++;
      $display("FAIL reset_data: alu_a=%b alu_b=%b alu_func=%b rsp_result=%b rsp_func=%b, want 0",
               alu_a, alu_b, alu_func, rsp_result, rsp_func);
    end
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single_add;
    logic r;
    rsp_ready = 1'b1;
    push(4'd3, 4'd5, 3'b000, 1'b0, 4'd8, 1'b1, r);
    cmd_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL add_lat_e0: rsp_valid=%b want 0", rsp_valid); end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || alu_a !== 4'd3 || alu_b !== 4'd5) begin
      errors++;
      $display("FAIL add_lat_e1: rsp_valid=%b alu_a=%0d alu_b=%0d, want 0/3/5", rsp_valid, alu_a, alu_b);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1) begin errors++; $display("FAIL add_lat_e2: rsp_valid=%b want 1", rsp_valid); end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL add_hold: rsp_valid=%b want 0", rsp_valid); end
    step(1);
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL add_drain: %0d left, want 0", sb.size()); end
  endtask

  task automatic test_stream;
    int n;
    rsp_ready = 1'b1;
    fork
      begin
        logic r;
        push(4'b0001, 4'b1111, 3'b100, 1'b0, 4'b1110, 1'b1, r);
        push(4'b0110, 4'b0011, 3'b010, 1'b0, 4'b0010, 1'b1, r);
        push(4'b0010, 4'b0101, 3'b001, 1'b0, 4'b1101, 1'b1, r);
        push(4'b0100, 4'b0101, 3'b110, 1'b0, 4'b0001, 1'b1, r);
        cmd_valid = 1'b0;
      end
      count_run(n);
    join
    step(1);
    checks++;
    if (n != 4) begin errors++; $display("FAIL stream_run: %0d consecutive, want 4", n); end
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL stream_drain: %0d left, want 0", sb.size()); end
  endtask

  task automatic test_backpressure;
    int n;
    logic r;
    rsp_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      push(DL'(i), 4'd1, 3'b000, 1'b0, DL'(i + 1), (i < DEPTH + 2), r);
      checks++;
      if (r !== 1'(i < DEPTH + 2)) begin
        errors++;
        $display("FAIL bp_ready[%0d]: cmd_ready=%b want %b", i, r, (i < DEPTH + 2));
      end
    end
    cmd_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (alu_a !== 4'd1 || alu_b !== 4'd1 || alu_func !== 3'b000 || rsp_result !== 4'd1 || rsp_valid !== 1'b1) begin
        errors++;
        $display("FAIL bp_stall[%0d]: alu_a=%0d alu_b=%0d func=%b rsp=%0d v=%b, want 1/1/000/1/1",
                 k, alu_a, alu_b, alu_func, rsp_result, rsp_valid);
      end
    end
    step(1);
    rsp_ready = 1'b1;
    count_run(n);
    step(1);
    checks++;
    if (n != DEPTH + 2) begin errors++; $display("FAIL bp_run: %0d consecutive, want %0d", n, DEPTH + 2); end
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL bp_drain: %0d left, want 0", sb.size()); end
  endtask

  task automatic test_acc;
    int n;
    logic [DL-1:0] e2, e3;
`ifdef ALU_CMD_SEQ_ACC_EN
    e2 = 4'd6;  e3 = 4'd2;
`else
    e2 = 4'd3;  e3 = 4'b1100;
`endif
    rsp_ready = 1'b1;
    fork
      begin
        logic r;
        push(4'd1, 4'd2, 3'b000, 1'b0, 4'd3, 1'b1, r);
        push(4'd0, 4'd3, 3'b000, 1'b1, e2, 1'b1, r);
        push(4'd0, 4'd4, 3'b001, 1'b1, e3, 1'b1, r);
        cmd_valid = 1'b0; cmd_acc = 1'b0;
      end
      count_run(n);
    join
    step(1);
    checks++;
    if (n != 3) begin errors++; $display("FAIL acc_run: %0d consecutive, want 3", n); end
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL acc_drain: %0d left, want 0", sb.size()); end
  endtask

  task automatic test_reset_midflight;
    logic r;
    int seen;
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(DL'(i + 2), 4'd3, 3'b011, 1'b0, '0, 1'b0, r);
    cmd_valid = 1'b0;
    step(2);
    checks++;
    if (rsp_valid !== 1'b1 || dut.count !== 3'd3) begin
      errors++;
      $display("FAIL rst_pre: rsp_valid=%b count=%0d, want 1/3", rsp_valid, dut.count);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || dut.op_valid !== 1'b0 || dut.count !== 3'd0) begin
      errors++;
      $display("FAIL rst_flush: rsp_valid=%b op_valid=%b count=%0d, want 0/0/0",
               rsp_valid, dut.op_valid, dut.count);
    end
    #2 rst_n = 1'b1;
    rsp_ready = 1'b1;
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: cmd_ready=%b want 1", cmd_ready); end
    seen = 0;
    repeat (8) begin @(negedge clk); if (rsp_valid) seen++; end
    step(1);
    checks++;
    if (seen != 0) begin errors++; $display("FAIL rst_norsp: %0d response cycles, want 0", seen); end
  endtask

  task automatic test_wrap;
    int max_cnt;
    rsp_ready = 1'b1;
    max_cnt = 0;
    fork
      begin
        logic r;
        logic [DL-1:0] a, b;
        logic [2:0] f;
        for (int i = 0; i < 3 * DEPTH; i++) begin
          a = DL'($urandom_range(0, 15));
          b = DL'($urandom_range(0, 15));
          f = 3'($urandom_range(0, 7));
          push(a, b, f, 1'b0, ref_alu(a, b, f), 1'b1, r);
        end
        cmd_valid = 1'b0;
      end
      for (int k = 0; k < 3 * DEPTH + 4; k++) begin
        @(negedge clk);
        if (int'(dut.count) > max_cnt) max_cnt = int'(dut.count);
      end
    join
    step(4);
    checks++;
    if (max_cnt > 2) begin errors++; $display("FAIL wrap_count: max count=%0d, want <=2", max_cnt); end
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL wrap_drain: %0d left, want 0", sb.size()); end
  endtask

  initial begin
    test_reset;
    test_single_add;
    test_stream;
    test_backpressure;
    test_acc;
    test_reset_midflight;
    test_wrap;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/alu_cmd_seq.md
# alu_cmd_seq

Command sequencer that sits directly upstream of `alu`. It accepts ALU commands (operands plus `func`) over a valid/ready handshake and buffers them in a small FIFO. It issues them one per cycle to `alu` through a registered operand stage, then captures each combinational ALU result into a response register with its own valid/ready handshake. An optional accumulator mode lets a command take operand `a` from the previous result, which allows chained arithmetic without a software round-trip.

## Interface
- `DATA_LEN`, default 4: operand and result width; must match the attached `alu`.
- `DEPTH`, default 4: command FIFO entries; power of two, ≥2.

- `clk`  in  1  sole clock; rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  FIFO not full.
- `cmd_a`, `cmd_b`  in  DATA_LEN  operands.
- `cmd_func`  in  3  ALU function code, passed through unchanged.
- `cmd_acc`  in  1  use accumulator as operand a (see Configuration).
- `alu_a`, `alu_b`  out  DATA_LEN  registered operands to `alu`.
- `alu_func`  out  3  registered function to `alu`.
- `alu_result`  in  DATA_LEN  combinational result from `alu`.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  consumer accepts response.
- `rsp_result`  out  DATA_LEN  captured result.
- `rsp_func`  out  3  func of the captured result.

## Operation
- The pipeline is FIFO → operand stage (`op_valid`, `alu_a/b/func`) → `alu` (combinational) → response register.
- Push: `cmd_valid && cmd_ready` at a clock edge writes {a, b, func, acc} at the tail.
- `cmd_ready` is `!full` and is combinational from the occupancy counter (width clog2(DEPTH)+1).
- `rsp_load` = `op_valid && (!rsp_valid || rsp_ready)`.
- `op_load` = FIFO non-empty `&& (!op_valid || rsp_load)`. It pops the head into the operand stage.
- On `rsp_load`: `rsp_result` ← `alu_result`, `rsp_func` ← `alu_func`, `rsp_valid` ← 1.
- On `rsp_ready && !rsp_load`: `rsp_valid` ← 0.
- If `op_valid && !op_load && rsp_load`, then `op_valid` ← 0.
- Operand-stage FSM, with the state derived from registered flags:
  - IDLE (`!op_valid`): goes to BUSY on `op_load`.
  - BUSY (`op_valid`, response slot free or draining): stays in BUSY if `op_load`, otherwise goes to IDLE.
  - STALL (`op_valid && rsp_valid && !rsp_ready`): the operand stage and `alu_*` outputs are held stable; goes to BUSY when `rsp_ready` rises.
- Simultaneous push and pop: both occur and occupancy is unchanged. A push while full is ignored because `cmd_ready` = 0.
- FIFO pointers wrap modulo DEPTH. Full = count == DEPTH; empty = count == 0.
- `rsp_result` is `alu_result` unmodified. For compare functions (110, 111) this is the ALU's zero-extended single bit.
- Arithmetic wraps at DATA_LEN bits; no flags are exported.

## Timing
- Reset values: `cmd_ready` = 1; `alu_a`, `alu_b`, `alu_func`, `rsp_result`, `rsp_func` = 0; `rsp_valid` = 0.
- Reset also clears FIFO count/pointers, `op_valid`, and the accumulator.
- Asserting `rst_n` low mid-operation flushes every in-flight command immediately (asynchronously). There is no partial response.
- Latency, empty block: command accepted at edge 0 → operand stage loaded at edge 1 → `rsp_valid` = 1 after edge 2.
- Throughput: one command per cycle while `rsp_ready` = 1.
- Capacity with `rsp_ready` held at 0: DEPTH + 2 commands (FIFO, operand stage, response).
- `alu_*` change only at an `op_load` edge.

## Configuration
- `ALU_CMD_SEQ_ACC_EN` defined:
  - Accumulator register `acc` (reset 0) is updated with `alu_result` on every `rsp_load`.
  - At `op_load`, `alu_a` ← `acc` if the head's `cmd_acc` = 1. If `rsp_load` occurs on the same edge, the value forwarded is `alu_result`, not the stale `acc`.
- Not defined:
  - `cmd_acc` is ignored (port kept, unconnected internally) and no accumulator logic is built.
  - `alu_a` always comes from `cmd_a`.

## Test plan
- Single add: push a=3, b=5, func=000 into an idle block with `rsp_ready` = 1 → `rsp_valid` after edge 2, `rsp_result` = 8, `rsp_func` = 000, held 1 cycle.
- Stream: push 0001-xor-1111, 0110-and-0011, 0010-sub-0101, 0100-less-0101 back-to-back → responses 1110, 0010, 1101, 0001 on consecutive cycles, in order.
- Backpressure: `rsp_ready` = 0, push 8 adds (a=i, b=1):
  - `cmd_ready` drops after 6 accepts; `alu_*` stay stable; `rsp_result` holds 1.
  - Release `rsp_ready` → results 1…6 on consecutive cycles, none lost or duplicated.
- Accumulator (macro on): back-to-back 1+2 (acc=0), then acc+3 (acc=1), then acc-4 (acc=1) → results 3, 6, 2 (the forwarding path is exercised). With the macro off, the same stimulus with `cmd_a` = 0 on the later commands → results 3, 3, 1100.
- Reset mid-flight: 3 commands queued and `rsp_valid` = 1, pulse `rst_n` low between edges → `rsp_valid`, `op_valid`, and count are 0 immediately; after release `cmd_ready` = 1 and no response appears.
- Full/empty wrap: with `rsp_ready` = 1, push and pop continuously for 3×DEPTH commands → count never exceeds 2, and every result matches its command.
